// File: rtl/irq_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_arbiter_pkg
// Description : Shared register offsets, state encodings and bus constants
//               for the interrupt arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_arbiter_pkg;

    localparam logic        c_rst_enable    = 1'b1;
    localparam logic        c_write_enable  = 1'b1;
    localparam logic [31:0] c_zero_word     = 32'h0000_0000;
    localparam logic        c_int_assert    = 1'b1;
    localparam logic        c_int_deassert  = 1'b0;

    localparam logic [4:0]  c_addr_enable   = 5'h00;
    localparam logic [4:0]  c_addr_pending  = 5'h04;
    localparam logic [4:0]  c_addr_claim    = 5'h08;
    localparam logic [4:0]  c_addr_complete = 5'h0C;
    localparam logic [4:0]  c_addr_status   = 5'h10;

    localparam logic [1:0]  c_st_idle       = 2'd0;
    localparam logic [1:0]  c_st_req        = 2'd1;
    localparam logic [1:0]  c_st_service    = 2'd2;

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : irq_prio_enc
// Description : Combinational fixed-priority encoder; lowest set index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc #(
    parameter int W    = 8,
    parameter int ID_W = 3
) (
    input  logic [W-1:0]    i_req,
    output logic            o_valid,
    output logic [ID_W-1:0] o_id
);

    // Scan high to low so the lowest asserted index is the last assignment.
    always_comb begin
        o_valid = 1'b0;
        o_id    = '0;
        for (int k = W - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                o_valid = 1'b1;
                o_id    = ID_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : irq_arbiter
// Description : Memory-mapped fixed-priority interrupt controller with a
//               claim/complete handshake for level-sensitive sources.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        data_i,
    input  logic [31:0]        addr_i,
    input  logic               we_i,
    input  logic               re_i,
    input  logic [NUM_SRC-1:0] irq_src_i,
    output logic [31:0]        data_o,
    output logic               irq_o,
    output logic [ID_W-1:0]    irq_id_o
);

    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_in_service;
    logic [1:0]         r_state;
    logic               r_irq;
    logic [ID_W-1:0]    r_irq_id;
    logic [ID_W-1:0]    r_svc_id;

    logic [4:0]         w_addr;
    logic               w_win_valid;
    logic [ID_W-1:0]    w_win_id;
    logic               w_claim;
    logic               w_complete;
    logic [NUM_SRC-1:0] w_claim_mask;
    logic [NUM_SRC-1:0] w_gate_set;
    logic [31:0]        w_rdata;
    logic               w_unused_bits;

    assign w_addr        = addr_i[4:0];
    assign w_unused_bits = ^{addr_i[31:5], data_i};

    irq_prio_enc #(
        .W    (NUM_SRC),
        .ID_W (ID_W)
    ) u_prio_enc (
        .i_req   (r_pending & r_enable),
        .o_valid (w_win_valid),
        .o_id    (w_win_id)
    );

    assign w_claim      = re_i && (w_addr == c_addr_claim) && (r_state == c_st_req);
    assign w_complete   = (we_i == c_write_enable) && (w_addr == c_addr_complete) &&
                          (r_state == c_st_service) && (data_i[ID_W-1:0] == r_svc_id);
    assign w_claim_mask = w_claim ? (NUM_SRC'(1) << r_irq_id) : '0;
    // Gateway stays shut while a source is pending or being serviced.
    assign w_gate_set   = irq_src_i & ~r_pending & ~r_in_service;

    always_ff @(posedge clk) begin
        if (rst == c_rst_enable) begin
            r_enable     <= '0;
            r_pending    <= '0;
            r_in_service <= '0;
            r_state      <= c_st_idle;
            r_irq        <= c_int_deassert;
            r_irq_id     <= '0;
            r_svc_id     <= '0;
        end else begin
            r_pending <= (r_pending | w_gate_set) & ~w_claim_mask;

            if ((we_i == c_write_enable) && (w_addr == c_addr_enable)) begin
                r_enable <= data_i[NUM_SRC-1:0];
            end

            case (r_state)
                c_st_idle: begin
                    if (w_win_valid) begin
                        r_state  <= c_st_req;
                        r_irq    <= c_int_assert;
                        r_irq_id <= w_win_id;
                    end
                end
                c_st_req: begin
                    if (w_claim) begin
                        r_in_service <= r_in_service | w_claim_mask;
                        r_svc_id     <= r_irq_id;
                        r_state      <= c_st_service;
                        r_irq        <= c_int_deassert;
                    end else if (!w_win_valid) begin
                        r_state <= c_st_idle;
                        r_irq   <= c_int_deassert;
                    end else begin
                        r_irq_id <= w_win_id;
                    end
                end
                c_st_service: begin
                    if (w_complete) begin
                        r_in_service <= '0;
                        r_svc_id     <= '0;
                        r_state      <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_irq   <= c_int_deassert;
                end
            endcase
        end
    end

    always_comb begin
        w_rdata = c_zero_word;
        if (rst != c_rst_enable) begin
            case (w_addr)
                c_addr_enable:  w_rdata[NUM_SRC-1:0] = r_enable;
                c_addr_pending: w_rdata[NUM_SRC-1:0] = r_pending;
                c_addr_claim: begin
                    if (r_state == c_st_req) begin
                        w_rdata[31]       = 1'b1;
                        w_rdata[ID_W-1:0] = r_irq_id;
                    end
                end
                c_addr_status: begin
                    w_rdata[17:16]    = r_state;
                    w_rdata[ID_W-1:0] = r_svc_id;
                end
                default: w_rdata = c_zero_word;
            endcase
        end
    end

    assign data_o   = w_rdata;
    assign irq_o    = r_irq;
    assign irq_id_o = r_irq_id;

endmodule
`default_nettype wire

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Memory-mapped interrupt controller on the peripheral bus, beside the timer and other interrupt-capable peripherals.
- Captures up to NUM_SRC level interrupt lines (the timer's int_sig_o is source 0) and arbitrates them by fixed priority.
- Presents one registered request (irq_o plus irq_id_o) to the core's interrupt logic.
- Sequences each interrupt through a claim/complete handshake, so a level source cannot re-trigger before software finishes servicing it.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..31).
- ID_W, 3, width of a source id; must satisfy 2^ID_W >= NUM_SRC.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- data_i  in  32  write data.
- addr_i  in  32  register address; only addr_i[4:0] is decoded.
- we_i  in  1  write strobe.
- re_i  in  1  read strobe; qualifies the claim side effect.
- irq_src_i  in  NUM_SRC  level interrupt inputs, synchronous to clk.
- data_o  out  32  combinational read data.
- irq_o  out  1  registered interrupt request to the core.
- irq_id_o  out  ID_W  registered id of the requesting source.

Behaviour:
- Register map (addr_i[4:0]); unmapped offsets read 0 and writes to them are ignored:
  - 0x00 ENABLE: RW, bits [NUM_SRC-1:0]; upper bits read 0.
  - 0x04 PENDING: RO.
  - 0x08 CLAIM: read returns {bit31 = valid, [ID_W-1:0] = id}.
  - 0x0C COMPLETE: WO, reads 0.
  - 0x10 STATUS: RO, {[17:16] = state, [ID_W-1:0] = in-service id}.
- Reset: enable, pending and in_service are 0; state is IDLE; irq_o = 0; irq_id_o = 0; data_o = 0 while rst is high.
- Gateway: pending[k] is set at a clock edge when irq_src_i[k]=1, pending[k]=0 and in_service[k]=0.
  - Pending is cleared only by a claim. A source dropping its line does not clear pending.
- Winner: lowest index k with pending[k] & enable[k] (fixed priority, source 0 highest).
- State machine, encoded IDLE=0, REQ=1, SERVICE=2:
  - IDLE: irq_o=0. If a winner exists, go to REQ, irq_o<=1, irq_id_o<=winner.
  - REQ: irq_id_o is re-latched to the current winner every cycle, so a higher-priority arrival preempts before the claim. If no winner remains (enable cleared), go to IDLE with irq_o<=0.
    - A claim (re_i & addr==0x08) returns {1, irq_id_o}. At that edge: pending[id] clears, in_service[id] sets, go to SERVICE, irq_o<=0.
  - SERVICE: irq_o=0 and no new request is presented; only one source may be in service. A COMPLETE write with data_i[ID_W-1:0] equal to the in-service id clears in_service and goes to IDLE. A mismatched id is ignored.
- A claim read in IDLE or SERVICE returns 0 and has no side effect. A read without re_i never claims.
- Latency: a source rising before edge N sets pending at N. irq_o asserts at edge N+1 if the source is enabled and the state is IDLE. After a complete, the next request is at the earliest 2 edges later.
- Simultaneous events:
  - Complete and a re-asserted source in the same cycle: the gateway is still closed at that edge, so pending sets at the following edge.
  - A write to ENABLE in the same cycle as a claim: the claim uses the latched irq_id_o and the write takes effect normally.
  - A source asserting in the same cycle it is claimed: no effect, because pending is already 1.
- Reset mid-service drops all state to reset values. Sources still high re-pend one edge after rst falls.

Decomposition:
- Shared defines: register offsets and the state encodings. Reuse the existing RstEnable, WriteEnable, ZeroWord and INT_ASSERT/INT_DEASSERT defines.
- Sub-module irq_prio_enc: combinational lowest-index priority encoder (masked vector in -> valid, id out). It is also reusable by a future bus arbiter.

Test Plan:
- Reset, then read all offsets -> 0x00 through 0x10 all read 0; irq_o=0.
- ENABLE=0x01; raise src0 -> irq_o=1 and irq_id_o=0 two edges later. Claim read -> 0x80000000. Hold src0 high -> no re-request. COMPLETE write 0 -> irq_o=1 again two edges later.
- ENABLE=0xFF; raise src5 and src2 together -> claim returns 0x80000002; after COMPLETE write 2, claim returns 0x80000005.
- ENABLE=0xFF; src6 in REQ, then src1 rises before the claim -> irq_id_o changes 6 to 1 and the claim returns 0x80000001; PENDING still shows bit 6.
- In SERVICE of id 3: COMPLETE write 4 -> STATUS unchanged (state=2); read CLAIM -> 0; COMPLETE write 3 -> state=0.
- Pend src7 with ENABLE=0 -> irq_o stays 0 and PENDING=0x80. Write ENABLE=0x80 -> irq_o=1. Assert rst for 1 cycle in SERVICE -> all registers 0, then src7 still high re-pends.
